// File: rtl/x_stream_serializer.sv
// Parallel-to-serial stimulus source for the Mealy FSM block: takes one word over valid/ready
// and shifts its low `len` bits out MSB-first on `x`, with optional back-to-back replays.
module x_stream_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   CNT_W      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_len,
    input  logic [1:0]       in_repeat,
    output logic             x,
    output logic             busy,
    output logic             frame_start,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [CNT_W-1:0] len;
        logic [1:0]       rep;
    } req_t;

    state_t           state_q, state_n;
    req_t             req_q, req_n;
    logic [WIDTH-1:0] shreg_q, shreg_n;
    logic [CNT_W-1:0] bit_q, bit_n;
    logic             x_n, busy_n, fs_n, done_n;
    logic [CNT_W-1:0] len_c;
    logic [WIDTH-1:0] aligned;

    assign in_ready = (state_q == S_IDLE) && !rst;

    // The active field is left-justified so the next bit is always at the shift register MSB.
    assign len_c   = (in_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_len;
    assign aligned = in_data << (CNT_W'(WIDTH) - len_c);

    always_comb begin
        state_n = state_q;
        req_n   = req_q;
        shreg_n = shreg_q;
        bit_n   = bit_q;
        x_n     = x;
        busy_n  = busy;
        fs_n    = 1'b0;
        done_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_n    = IDLE_LEVEL;
                busy_n = 1'b0;
                if (in_valid) begin
                    if (len_c == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_SHIFT;
                        req_n   = '{word: aligned, len: len_c, rep: in_repeat};
                        x_n     = aligned[WIDTH-1];
                        shreg_n = aligned << 1;
                        bit_n   = len_c - CNT_W'(1);
                        busy_n  = 1'b1;
                        fs_n    = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // bit_q counts bits still to follow the one currently on x.
                if (bit_q != '0) begin
                    x_n     = shreg_q[WIDTH-1];
                    shreg_n = shreg_q << 1;
                    bit_n   = bit_q - CNT_W'(1);
                end else if (req_q.rep != 2'd0) begin
                    req_n.rep = req_q.rep - 2'd1;
                    x_n       = req_q.word[WIDTH-1];
                    shreg_n   = req_q.word << 1;
                    bit_n     = req_q.len - CNT_W'(1);
                    fs_n      = 1'b1;
                end else begin
                    state_n = S_DONE;
                    x_n     = IDLE_LEVEL;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                x_n     = IDLE_LEVEL;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                x_n     = IDLE_LEVEL;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            shreg_q     <= '0;
            bit_q       <= '0;
            x           <= IDLE_LEVEL;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_n;
            req_q       <= req_n;
            shreg_q     <= shreg_n;
            bit_q       <= bit_n;
            x           <= x_n;
            busy        <= busy_n;
            frame_start <= fs_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_x_stream_serializer.sv
// Bench for x_stream_serializer: directed frames plus random traffic, every cycle compared
// against a queue of expected per-cycle outputs expanded from each accepted word.
module tb_x_stream_serializer;

    localparam int   WIDTH = 8;
    localparam int   CNT_W = 4;
    localparam logic IDLE  = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_len = '0;
    logic [1:0]       in_repeat = '0;
    logic             x, busy, frame_start, done;

    x_stream_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDLE_LEVEL(IDLE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_repeat(in_repeat),
        .x(x), .busy(busy), .frame_start(frame_start), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic busy;
        logic fs;
        logic done;
    } exp_t;

    exp_t q[$];
    exp_t cur, idle_e;
    int   n_chk = 0, n_pass = 0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit model_ready();
        return (q.size() == 0) && !cur.done && !rst;
    endfunction

    // Expand one accepted word into its cycle-by-cycle output sequence.
    task automatic push_frame(input logic [WIDTH-1:0] d, input int l, input int r);
        exp_t e;
        int   len;
        len = (l > WIDTH) ? WIDTH : l;
        if (len > 0) begin
            for (int k = 0; k < len * (r + 1); k++) begin
                e.x    = d[len - 1 - (k % len)];
                e.busy = 1'b1;
                e.fs   = ((k % len) == 0);
                e.done = 1'b0;
                q.push_back(e);
            end
        end
        e = idle_e;
        e.done = 1'b1;
        q.push_back(e);
    endtask

    task automatic step();
        bit               acc;
        logic [WIDTH-1:0] d;
        int               l, r;
        acc = model_ready() && in_valid;
        d = in_data;
        l = int'(in_len);
        r = int'(in_repeat);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            cur = idle_e;
        end else begin
            if (acc) push_frame(d, l, r);
            cur = (q.size() != 0) ? q.pop_front() : idle_e;
        end
        last_acc = acc && !rst;
        chk("x", 32'(x), 32'(cur.x));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("frame_start", 32'(frame_start), 32'(cur.fs));
        chk("done", 32'(done), 32'(cur.done));
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || cur.done) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q.size() != 0 || cur.done), 32'(0));
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int l, input int r, input bit wait_end);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_len    = CNT_W'(l);
        in_repeat = 2'(r);
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        chk("accept_timeout", 32'(last_acc), 32'(1));
        in_valid = 1'b0;
        if (wait_end) drain();
    endtask

    initial begin
        idle_e = '{x: IDLE, busy: 1'b0, fs: 1'b0, done: 1'b0};
        cur    = idle_e;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        send(8'b1011_0010, 8, 0, 1'b1);
        send(8'hF6, 3, 0, 1'b1);
        send(8'h02, 2, 2, 1'b1);
        send(8'h00, 0, 3, 1'b1);
        send(8'hA5, 12, 0, 1'b1);
        send(8'hA5, 8, 1, 1'b1);

        // Back-pressure: second word held valid while the first is still shifting.
        send(8'hC3, 8, 1, 1'b0);
        send(8'h5A, 7, 0, 1'b1);

        // Reset during the 4th bit of a frame.
        send(8'hB2, 8, 0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send(8'h96, 8, 0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = WIDTH'($urandom);
            in_len    = CNT_W'($urandom_range(0, 15));
            in_repeat = 2'($urandom_range(0, 3));
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
